// File: rtl/seq_detect_ctrl.sv
// Word-fed programmable serial pattern detector: words are serialized MSB-first
// into a bit history, matched against a runtime pattern, counted, and raise a threshold irq.
module seq_detect_ctrl #(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               clr_count,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic               busy,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               irq
);

  localparam int BC_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FILL_W = $clog2(PAT_MAX + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_next;
  logic [BC_W-1:0]    bitcnt, bitcnt_next;
  logic [WORD_W-1:0]  word_q, word_next;
  logic [PAT_MAX-1:0] hist, hist_next;
  logic [PAT_MAX-1:0] pattern, len_mask;
  logic [FILL_W-1:0]  fill, fill_next;
  logic [FILL_W-1:0]  len, len_clamped;
  logic [CNT_W-1:0]   thresh, count_next;
  logic               handshake, last_bit, cur_bit, cfg_load, match;

  assign busy      = (state == SHIFT);
  assign last_bit  = (bitcnt == BC_W'(WORD_W - 1));
  // Ready is gated by reset so nothing is offered while the block is held in reset.
  assign in_ready  = reset & enable & ((state == IDLE) | ((state == SHIFT) & last_bit));
  assign handshake = in_valid & in_ready;
  assign cfg_load  = cfg_we & ~busy;
  assign cur_bit   = word_q[BC_W'(WORD_W - 1) - bitcnt];

  always_comb begin
    len_clamped = FILL_W'(cfg_len);
    if (cfg_len == 4'd0)
      len_clamped = FILL_W'(1);
    else if (int'(cfg_len) > PAT_MAX)
      len_clamped = FILL_W'(PAT_MAX);
  end

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_MAX; i++)
      len_mask[i] = (i < int'(len));
  end

  // Next-state logic; a cfg load only happens in IDLE so its history clear never races a shift.
  always_comb begin
    state_next  = state;
    bitcnt_next = bitcnt;
    word_next   = word_q;
    hist_next   = hist;
    fill_next   = fill;
    match       = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_next  = SHIFT;
          bitcnt_next = '0;
          word_next   = in_data;
        end
      end
      SHIFT: begin
        hist_next = {hist[PAT_MAX-2:0], cur_bit};
        if (fill != FILL_W'(PAT_MAX))
          fill_next = fill + FILL_W'(1);
        match = (fill_next >= len) && (((hist_next ^ pattern) & len_mask) == '0);
        if (last_bit) begin
          if (handshake) begin
            bitcnt_next = '0;
            word_next   = in_data;
          end else begin
            state_next = IDLE;
          end
        end else begin
          bitcnt_next = bitcnt + BC_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    if (cfg_load) begin
      hist_next = '0;
      fill_next = '0;
    end
  end

  always_comb begin
    count_next = match_count;
    if (match && (match_count != '1))
      count_next = match_count + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      bitcnt <= '0;
      word_q <= '0;
      hist   <= '0;
      fill   <= '0;
    end else begin
      state  <= state_next;
      bitcnt <= bitcnt_next;
      word_q <= word_next;
      hist   <= hist_next;
      fill   <= fill_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern <= '0;
      len     <= FILL_W'(1);
      thresh  <= '0;
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      len     <= len_clamped;
      thresh  <= cfg_thresh;
    end
  end

  // Count and irq move with the detected pulse; clr_count wins and drops that cycle's match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      detected    <= 1'b0;
      match_count <= '0;
      irq         <= 1'b0;
    end else begin
      detected <= match;
      if (clr_count) begin
        match_count <= '0;
        irq         <= 1'b0;
      end else begin
        match_count <= count_next;
        if ((thresh != '0) && (count_next >= thresh))
          irq <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: a bit-level reference model queues expected detection
// cycles per accepted word; a vector table plus hand-written corner sequences check counts.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic [7:0] cfg_thresh = '0;
  logic       clr_count = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, busy, detected, irq;
  logic [7:0] match_count;

  seq_detect_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_thresh(cfg_thresh),
    .clr_count(clr_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .detected(detected),
    .match_count(match_count), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] pat;
    logic [3:0] len;
    logic [7:0] word;
    int         exp_dets;
  } vec_t;

  vec_t       vecs [9];
  int         sb_q [$];
  int         checks = 0;
  int         passes = 0;
  int         pulse_cnt = 0;
  int         last_hs = 0;
  logic [7:0] m_hist = '0;
  logic [7:0] m_pat = '0;
  int         m_fill = 0;
  int         m_len = 1;

  task automatic checkOutput(input string name, input longint actual, input longint required);
    checks++;
    if (actual == required) passes++;
    else $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
  endtask

  // Every DUT sample happens at the falling edge, where detected pulses are matched to the queue.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (detected) begin
      pulse_cnt++;
      if (sb_q.size() == 0) checkOutput("stray detected at cycle", cyc, -1);
      else checkOutput("detect cycle", cyc, sb_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic modelReset();
    m_hist = '0; m_fill = 0; m_pat = '0; m_len = 1;
    sb_q.delete();
  endtask

  task automatic modelWord(input logic [7:0] w, input int hs);
    logic [7:0] mask;
    logic       b;
    mask = (m_len >= 8) ? 8'hFF : 8'((1 << m_len) - 1);
    for (int i = 0; i < 8; i++) begin
      b = w[7 - i];
      m_hist = {m_hist[6:0], b};
      if (m_fill < 8) m_fill++;
      if (m_fill >= m_len && ((m_hist ^ m_pat) & mask) == 8'h00)
        sb_q.push_back(hs + 1 + i);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] w);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && guard < 40) begin
      tick();
      guard++;
    end
    checkOutput("in_ready before handshake", in_ready, 1);
    last_hs = cyc + 1;
    modelWord(w, last_hs);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic cfgWrite(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_thresh = t;
    m_pat  = p;
    m_len  = (l == 0) ? 1 : ((l > 8) ? 8 : int'(l));
    m_hist = '0;
    m_fill = 0;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic clrCount();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int prev_hs;
    int guard;
    vecs[0] = '{8'h0B, 4'd4,  8'hB6, 2};
    vecs[1] = '{8'h01, 4'd1,  8'h07, 3};
    vecs[2] = '{8'h00, 4'd0,  8'hF0, 4};
    vecs[3] = '{8'hFF, 4'd8,  8'hFF, 1};
    vecs[4] = '{8'h01, 4'd2,  8'hAA, 3};
    vecs[5] = '{8'hA5, 4'd15, 8'hA5, 1};
    vecs[6] = '{8'h07, 4'd3,  8'hFF, 6};
    vecs[7] = '{8'h0B, 4'd4,  8'h00, 0};
    vecs[8] = '{8'h06, 4'd4,  8'h66, 2};

    // Reset state, including in_ready held low while reset is asserted.
    enable = 1'b1;
    #1;
    checkOutput("in_ready in reset", in_ready, 0);
    checkOutput("busy in reset", busy, 0);
    checkOutput("detected in reset", detected, 0);
    checkOutput("match_count in reset", match_count, 0);
    checkOutput("irq in reset", irq, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    checkOutput("in_ready after release", in_ready, 1);
    checkOutput("busy idle", busy, 0);
    checkOutput("match_count idle", match_count, 0);
    checkOutput("irq idle", irq, 0);

    for (int v = 0; v < 9; v++) begin
      cfgWrite(vecs[v].pat, vecs[v].len, 8'h00);
      clrCount();
      pulse_cnt = 0;
      applyStimulus(vecs[v].word);
      idle(12);
      checkOutput($sformatf("vec%0d pulses", v), pulse_cnt, vecs[v].exp_dets);
      checkOutput($sformatf("vec%0d match_count", v), match_count, vecs[v].exp_dets);
      checkOutput($sformatf("vec%0d pending", v), sb_q.size(), 0);
    end

    // Match spanning a word boundary with gapless streaming.
    cfgWrite(8'h0B, 4'd4, 8'h00);
    clrCount();
    pulse_cnt = 0;
    applyStimulus(8'h01);
    prev_hs = last_hs;
    applyStimulus(8'h60);
    checkOutput("gapless handshake spacing", last_hs - prev_hs, 8);
    checkOutput("busy across boundary", busy, 1);
    idle(12);
    checkOutput("boundary pulses", pulse_cnt, 1);
    checkOutput("boundary pending", sb_q.size(), 0);

    // Threshold interrupt rises with the third pulse, then clr_count drops it.
    cfgWrite(8'h01, 4'd1, 8'd3);
    clrCount();
    pulse_cnt = 0;
    applyStimulus(8'h07);
    repeat (12) begin
      tick();
      if (detected) checkOutput("irq vs pulse", irq, (pulse_cnt >= 3));
    end
    checkOutput("thresh match_count", match_count, 3);
    checkOutput("irq set", irq, 1);
    clrCount();
    checkOutput("count after clr", match_count, 0);
    checkOutput("irq after clr", irq, 0);

    // Saturation at 255, then clr_count beating a same-cycle increment.
    cfgWrite(8'h01, 4'd1, 8'h00);
    clrCount();
    for (int w = 0; w < 32; w++) applyStimulus(8'hFF);
    idle(12);
    checkOutput("saturated count", match_count, 255);
    checkOutput("saturation pending", sb_q.size(), 0);
    applyStimulus(8'hFF);
    guard = 0;
    while (!detected && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("pulse before clr", detected, 1);
    clrCount();
    checkOutput("clr priority", match_count, 0);
    idle(12);
    checkOutput("count after clr word", match_count, 6);

    // Configuration writes while busy are ignored.
    cfgWrite(8'h0B, 4'd4, 8'h00);
    clrCount();
    pulse_cnt = 0;
    applyStimulus(8'h00);
    cfg_we = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd1; cfg_thresh = 8'd1;
    tick();
    cfg_we = 1'b0;
    applyStimulus(8'hB6);
    idle(12);
    checkOutput("busy cfg pulses", pulse_cnt, 2);
    checkOutput("busy cfg count", match_count, 2);
    checkOutput("busy cfg irq", irq, 0);

    // Reset asserted at bitcnt 3 discards the word and any pending detections.
    cfgWrite(8'h01, 4'd1, 8'h00);
    applyStimulus(8'hFF);
    idle(3);
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("mid-word reset busy", busy, 0);
    checkOutput("mid-word reset detected", detected, 0);
    checkOutput("mid-word reset count", match_count, 0);
    checkOutput("mid-word reset in_ready", in_ready, 0);
    idle(2);
    reset = 1'b1;
    tick();
    checkOutput("in_ready after re-release", in_ready, 1);
    pulse_cnt = 0;
    idle(12);
    checkOutput("no stale pulses", pulse_cnt, 0);
    checkOutput("count after reset", match_count, 0);
    checkOutput("final pending", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Word-fed, programmable serial pattern-detection controller. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first into a bit-history register. It matches a runtime-configured pattern of 1..PAT_MAX bits, with overlapping matches and matches that span word boundaries. It counts detections and raises a level interrupt at a programmable threshold, so software or upstream logic can drive a sequence detector without bit-level pacing.

## Interface
- WORD_W, 8, width of input words; each word is shifted out over WORD_W cycles.
- PAT_MAX, 8, maximum pattern length in bits.
- CNT_W, 8, width of the match counter and the threshold.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. 0 = reset asserted.
- enable  in  1  allows new words to be accepted.
- cfg_we  in  1  configuration write strobe; honored only when busy=0.
- cfg_pattern  in  PAT_MAX  pattern bits; the low cfg_len bits are used, LSB = most recent bit.
- cfg_len  in  4  pattern length; 0 is treated as 1, values above PAT_MAX clamp to PAT_MAX.
- cfg_thresh  in  CNT_W  irq threshold; 0 disables irq.
- clr_count  in  1  synchronous clear of match_count and irq.
- in_valid  in  1  input word valid.
- in_data  in  WORD_W  input word.
- in_ready  out  1  controller can accept a word this cycle (combinational).
- busy  out  1  a word is being shifted (state SHIFT).
- detected  out  1  registered one-cycle pulse per match.
- match_count  out  CNT_W  saturating count of detections.
- irq  out  1  level interrupt.

## Operation
- States:
  - IDLE. Go to SHIFT on a handshake, when in_valid & in_ready.
  - SHIFT. Counts bitcnt from 0 to WORD_W-1 and consumes bit in_data[WORD_W-1-bitcnt] of the latched word.
  - On the bitcnt=WORD_W-1 cycle: go back to SHIFT with bitcnt=0 if a new handshake occurs, otherwise go to IDLE.
- in_ready = enable & (state==IDLE | (state==SHIFT & bitcnt==WORD_W-1)). This allows gapless streaming.
- Each SHIFT cycle updates the history: hist <= {hist[PAT_MAX-2:0], bit}. fill increments and saturates at PAT_MAX.
- Match condition: fill_next >= len, and the low len bits of hist_next equal the low len bits of the pattern.
  - When the condition holds, detected=1 on the next cycle.
  - Overlapping matches are allowed; history is not cleared on a match.
  - History persists across words.
- Deasserting enable mid-word: the current word completes, then the FSM goes to IDLE with in_ready=0. History is retained.
- cfg_we while busy=0 loads pattern, len and thresh, and clears hist and fill. cfg_we while busy=1 is ignored entirely.
- match_count increments on each detected pulse and saturates at 2^CNT_W-1.
- clr_count clears match_count and irq. It takes priority over an increment in the same cycle; that detection is lost.
- irq sets when thresh!=0 and match_count_next >= thresh. It stays set until clr_count or reset.
- A cfg_thresh change does not clear an already-set irq.

## Timing
- Reset values (immediate on reset=0, independent of clk):
  - state IDLE, bitcnt 0, hist 0, fill 0.
  - pattern 0, len 1, thresh 0.
  - busy 0, detected 0, match_count 0, irq 0.
  - in_ready 0 while reset is asserted; after release, in_ready = enable.
- Handshake at edge T:
  - MSB is consumed in cycle T+1; bit i (MSB=0) is consumed in cycle T+1+i.
  - A match ending on bit i gives detected high in cycle T+2+i.
  - match_count and irq update in the same cycle as the detected pulse.
- Back-to-back words: the next handshake happens on the last-bit cycle, with zero idle cycles between words.
- Reset asserted mid-word: the word is discarded and no partial detections are reported afterwards.

## Test plan
- Reset, then release with enable=1 and no stimulus:
  - All outputs hold their reset values.
  - in_ready=1 one cycle after release.
- Pattern match within one word:
  - Configure pattern=4'b1011, len=4. Send 0xB6 (bits 1,0,1,1,0,1,1,0) accepted at T.
  - Expect detected at T+5 and T+8, and match_count=2.
- Match across a word boundary:
  - Same configuration. Send 0x01 then 0x60 back-to-back; the second word is accepted on the last-bit cycle, T+8.
  - Expect exactly one detected pulse, at T+12, and busy held continuously.
- Threshold interrupt:
  - Configure len=1, pattern=1, thresh=3. Send 0x07.
  - Expect detected on the last 3 bits, irq rising with the third pulse, and match_count=3.
  - clr_count → match_count=0 and irq=0 on the next cycle.
- Saturation and clear priority:
  - Configure len=1, pattern=1. Send 32 words of 0xFF (256 matches).
  - Expect match_count to hold at 255.
  - Assert clr_count in the same cycle as a detected pulse → match_count=0.
- Illegal config and reset mid-word:
  - cfg_we during busy → configuration unchanged.
  - reset=0 at bitcnt=3 → all outputs at reset values immediately. After release, no stale detections appear.
